// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: the pipeline WB port has priority and divider
// results wait in a small FIFO. Pipeline writes kill older buffered writes (WAW), and a starvation counter requests a bubble.
module rf_wb_arbiter #(
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        wb_we,
   input  logic [4:0]  wb_waddr,
   input  logic [31:0] wb_wdata,
   input  logic        div_valid,
   input  logic [4:0]  div_waddr,
   input  logic [31:0] div_wdata,
   output logic        div_ready,
   input  logic [4:0]  raddr1,
   input  logic [4:0]  raddr2,
   output logic        stall_req,
   output logic        wb_hold_req,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

   typedef struct packed {
      logic        valid;
      logic        killed;
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } ent_t;

   ent_t          fifo [DEPTH];
   ent_t          head;
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic [SW-1:0] starve;
   logic          wb_win, push, pop, xfer;

   assign div_ready   = (count < DEPTH_C);
   assign xfer        = div_valid && div_ready;
   // Writes to r0 are accepted so the divider is never blocked, then dropped.
   assign push        = xfer && (div_waddr != 5'd0);
   assign wb_win      = wb_we && (wb_waddr != 5'd0);
   assign pop         = !wb_win && (count != '0);
   assign head        = fifo[rd_ptr];
   assign wb_hold_req = (starve == STARVE_C);

   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = 5'd0;
      rf_wdata = 32'd0;
      if (wb_win) begin
         rf_we    = 1'b1;
         rf_waddr = wb_waddr;
         rf_wdata = wb_wdata;
      end else if (pop) begin
         rf_we    = !head.killed;
         rf_waddr = head.waddr;
         rf_wdata = head.wdata;
      end
   end

   always_comb begin
      stall_req = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (fifo[i].valid && !fifo[i].killed &&
             (((raddr1 != 5'd0) && (fifo[i].waddr == raddr1)) ||
              ((raddr2 != 5'd0) && (fifo[i].waddr == raddr2))))
            stall_req = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         starve <= '0;
      end else begin
         if (wb_win) begin
            for (int i = 0; i < DEPTH; i++)
               if (fifo[i].valid && (fifo[i].waddr == wb_waddr)) fifo[i].killed <= 1'b1;
         end
         if (pop) begin
            fifo[rd_ptr].valid <= 1'b0;
            rd_ptr             <= rd_ptr + 1'b1;
         end
         // Placed last so a same-cycle pipeline write cannot kill the newer divider result.
         if (push) begin
            fifo[wr_ptr] <= '{valid: 1'b1, killed: 1'b0, waddr: div_waddr, wdata: div_wdata};
            wr_ptr       <= wr_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (pop || (count == '0))
            starve <= '0;
         else if (wb_win && (starve != STARVE_C))
            starve <= starve + 1'b1;
      end
   end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: inputs change 1ns after each rising edge and
// outputs are checked before the next edge.
module tb_rf_wb_arbiter;
   logic        clk, resetn;
   logic        wb_we, div_valid, div_ready, stall_req, wb_hold_req, rf_we;
   logic [4:0]  wb_waddr, div_waddr, raddr1, raddr2, rf_waddr;
   logic [31:0] wb_wdata, div_wdata, rf_wdata;
   logic [31:0] shadow [32] = '{default: 32'd0};
   int checks = 0;
   int errors = 0;

   rf_wb_arbiter #(.DEPTH(2), .STARVE_MAX(8)) dut (
      .clk(clk), .resetn(resetn),
      .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
      .div_valid(div_valid), .div_waddr(div_waddr), .div_wdata(div_wdata),
      .div_ready(div_ready), .raddr1(raddr1), .raddr2(raddr2),
      .stall_req(stall_req), .wb_hold_req(wb_hold_req),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Architectural register image as seen through the write port.
   always @(posedge clk) if (resetn && rf_we) shadow[rf_waddr] <= rf_wdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic dv, input logic [4:0] da, input logic [31:0] dd);
      wb_we = we; wb_waddr = wa; wb_wdata = wd;
      div_valid = dv; div_waddr = da; div_wdata = dd;
      #1;
   endtask

   task automatic chk_rf(input string tag, input logic we, input logic [4:0] wa, input logic [31:0] wd);
      chk({tag, "_we"}, 32'(rf_we), 32'(we));
      chk({tag, "_waddr"}, 32'(rf_waddr), 32'(wa));
      chk({tag, "_wdata"}, rf_wdata, wd);
   endtask

   initial begin
      resetn = 1'b0; raddr1 = '0; raddr2 = '0;
      drive(0, 0, 0, 0, 0, 0);
      chk("rst_ready", 32'(div_ready), 1);
      chk("rst_stall", 32'(stall_req), 0);
      chk("rst_hold", 32'(wb_hold_req), 0);
      chk_rf("rst", 0, 0, 0);
      tick();
      resetn = 1'b1;
      #1;

      // single result, one-cycle latency, no bypass
      drive(0, 0, 0, 1, 5, 32'h1234);
      chk("single_nobypass", 32'(rf_we), 0);
      tick();
      raddr1 = 5;
      drive(0, 0, 0, 0, 0, 0);
      chk("single_stall", 32'(stall_req), 1);
      chk_rf("single", 1, 5, 32'h1234);
      tick();
      chk("single_empty", 32'(rf_we), 0);
      chk("single_stall_clr", 32'(stall_req), 0);
      chk("single_ready", 32'(div_ready), 1);

      // r0 divider result discarded
      raddr1 = 0;
      drive(0, 0, 0, 1, 0, 32'hDEAD);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      chk("r0_drop", 32'(rf_we), 0);
      tick();

      // conflict: r7 wins for three cycles, r3 drains in the fourth
      drive(1, 7, 32'h77, 1, 3, 32'hAA);
      chk_rf("conf_c1", 1, 7, 32'h77);
      tick();
      raddr1 = 3;
      drive(1, 7, 32'h78, 0, 0, 0);
      chk_rf("conf_c2", 1, 7, 32'h78);
      chk("conf_stall_c2", 32'(stall_req), 1);
      tick();
      drive(1, 7, 32'h79, 0, 0, 0);
      chk_rf("conf_c3", 1, 7, 32'h79);
      chk("conf_stall_c3", 32'(stall_req), 1);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      chk_rf("conf_c4", 1, 3, 32'hAA);
      chk("conf_stall_c4", 32'(stall_req), 1);
      tick();
      chk("conf_stall_done", 32'(stall_req), 0);
      chk("conf_r7", shadow[7], 32'h79);
      raddr1 = 0;

      // full / backpressure
      drive(1, 7, 32'h1, 1, 10, 32'h10);
      tick();
      drive(1, 7, 32'h2, 1, 11, 32'h11);
      chk("full_ready_c2", 32'(div_ready), 1);
      tick();
      drive(1, 7, 32'h3, 1, 12, 32'h12);
      chk("full_ready_c3", 32'(div_ready), 0);
      tick();
      drive(0, 0, 0, 1, 12, 32'h12);
      chk("full_ready_pop", 32'(div_ready), 0);
      chk_rf("full_pop10", 1, 10, 32'h10);
      tick();
      chk("full_ready_resume", 32'(div_ready), 1);
      chk_rf("full_pop11", 1, 11, 32'h11);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      chk_rf("full_pop12", 1, 12, 32'h12);
      tick();
      chk("full_empty", 32'(rf_we), 0);

      // WAW kill
      drive(1, 1, 32'h5, 1, 9, 32'h1);
      tick();
      raddr2 = 9;
      drive(1, 9, 32'h2, 0, 0, 0);
      chk("waw_stall_before", 32'(stall_req), 1);
      chk_rf("waw_wb", 1, 9, 32'h2);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      chk("waw_stall_after", 32'(stall_req), 0);
      chk_rf("waw_drain", 0, 9, 32'h1);
      tick();
      chk("waw_final", shadow[9], 32'h2);
      raddr2 = 0;

      // same-cycle push and pipeline write to the same register: push survives
      drive(1, 4, 32'h40, 1, 4, 32'h44);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      chk_rf("samecyc", 1, 4, 32'h44);
      tick();

      // starvation
      drive(1, 1, 32'h0, 1, 6, 32'h66);
      tick();
      drive(1, 1, 32'h0, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         chk("starve_low", 32'(wb_hold_req), 0);
         tick();
      end
      chk("starve_hold", 32'(wb_hold_req), 1);
      tick();
      chk("starve_sat", 32'(wb_hold_req), 1);
      drive(0, 0, 0, 0, 0, 0);
      chk_rf("starve_drain", 1, 6, 32'h66);
      tick();
      chk("starve_clr", 32'(wb_hold_req), 0);
      chk("starve_empty", 32'(rf_we), 0);

      // reset mid-operation with two buffered results
      drive(1, 1, 32'h0, 1, 20, 32'h20);
      tick();
      drive(1, 1, 32'h0, 1, 21, 32'h21);
      tick();
      resetn = 1'b0; raddr1 = 20;
      drive(0, 0, 0, 0, 0, 0);
      chk("mid_rst_we", 32'(rf_we), 0);
      chk("mid_rst_ready", 32'(div_ready), 1);
      chk("mid_rst_stall", 32'(stall_req), 0);
      tick();
      resetn = 1'b1;
      #1;
      chk("mid_rst_we_rel", 32'(rf_we), 0);
      tick();
      chk("mid_rst_we_after", 32'(rf_we), 0);
      chk("mid_rst_r20", shadow[20], 32'h0);
      chk("mid_rst_r21", shadow[21], 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, giving the number of divider-result holding entries (power of two, 2..8).
REQ-002 The block SHALL have parameter STARVE_MAX, default 8, giving the consecutive-cycle limit before a pipeline hold is requested.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have these ports:
  clk  in  1  rising-edge clock
  resetn  in  1  asynchronous active-low reset
  wb_we  in  1  pipeline WB-stage write enable
  wb_waddr  in  5  pipeline WB destination register
  wb_wdata  in  32  pipeline WB write data
  div_valid  in  1  divider result valid
  div_waddr  in  5  divider destination register
  div_wdata  in  32  divider result data
  div_ready  out  1  holding buffer can accept a result
  raddr1  in  5  ID-stage read address 1
  raddr2  in  5  ID-stage read address 2
  stall_req  out  1  ID read hits a pending divider write
  wb_hold_req  out  1  request one pipeline bubble to drain the buffer
  rf_we  out  1  register-file write enable
  rf_waddr  out  5  register-file write address
  rf_wdata  out  32  register-file write data

Function
REQ-005 The block SHALL hold divider results in a DEPTH-entry FIFO of {valid, killed, waddr, wdata}, with binary read/write pointers that wrap modulo DEPTH and a count ranging 0..DEPTH.
REQ-006 div_ready SHALL equal (count < DEPTH) and SHALL depend only on registered state; a transfer occurs on a rising edge with div_valid && div_ready.
REQ-007 A transfer with div_waddr == 0 SHALL be accepted and discarded, leaving count unchanged.
REQ-008 The pipeline port SHALL have absolute priority: when wb_we && wb_waddr != 0, the outputs SHALL be rf_we=1, rf_waddr=wb_waddr, rf_wdata=wb_wdata, with no FIFO pop that cycle.
REQ-009 Otherwise, if count > 0, the block SHALL pop the head entry that cycle, driving rf_we = !head.killed, rf_waddr = head.waddr, rf_wdata = head.wdata.
REQ-010 Otherwise the outputs SHALL be rf_we=0, rf_waddr=0, rf_wdata=0.
REQ-011 The minimum latency from a divider transfer to its register-file write SHALL be 1 cycle; there is no combinational bypass from div_* to rf_*.
REQ-012 A push and a pop in the same cycle SHALL leave count unchanged and advance both pointers.
REQ-013 When the pipeline writes (per REQ-008), every valid entry whose waddr equals wb_waddr SHALL have killed set at that edge (WAW: the pipeline write is younger); an entry pushed in that same cycle SHALL NOT be killed.
REQ-014 stall_req SHALL be 1 when any valid, non-killed entry has a waddr equal to a nonzero raddr1 or raddr2; it SHALL be computed from registered state only.
REQ-015 A starvation counter SHALL increment each cycle in which count > 0 and the pipeline port wins; it SHALL clear on any pop or when count == 0, and saturate at STARVE_MAX.
REQ-016 wb_hold_req SHALL be 1 while the starvation counter equals STARVE_MAX; the pipeline then supplies a cycle with wb_we=0, the pop clears the counter, and wb_hold_req drops on the next cycle.
REQ-017 When the FIFO is full, div_ready SHALL be 0 even if a pop occurs that cycle; acceptance resumes on the following cycle.

Reset
REQ-018 When resetn is low, the block SHALL asynchronously clear count, both pointers, all valid/killed bits and the starvation counter.
REQ-019 During and after reset: div_ready=1, stall_req=0, wb_hold_req=0, rf_we=0, rf_waddr=0, rf_wdata=0 (with wb_we low).
REQ-020 Reset asserted mid-operation SHALL discard all buffered results without producing any write.

Verification
REQ-021 Single result: push (r5, 0x1234) with the pipeline idle -> the next cycle gives rf_we=1, rf_waddr=5, rf_wdata=0x1234, and count returns to 0.
REQ-022 Conflict: push (r3, 0xAA) while wb_we writes r7 for 3 cycles -> r7 writes occur in those cycles, r3 is written in cycle 4, and stall_req=1 for raddr1=3 until the r3 drain.
REQ-023 Full/backpressure: push 2 results with the pipeline busy -> div_ready=0 on the third cycle, and the third result is accepted only the cycle after the first pop.
REQ-024 WAW kill: buffered (r9, 0x1) then pipeline writes (r9, 0x2) -> the r9 drain has rf_we=0, the final r9 value is 0x2, and stall_req is 0 for r9 after the kill.
REQ-025 Starvation: count=1 with the pipeline writing every cycle -> wb_hold_req=1 after 8 cycles; a wb_we=0 cycle then drains the entry, and wb_hold_req=0 on the next cycle.
REQ-026 Reset mid-operation: count=2, then resetn low for 1 cycle -> no rf_we occurs, div_ready=1, stall_req=0.
